// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// The lock states are only reachable when ARB_LOCK_EN is defined.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    PRI_A  = 2'd0,
    PRI_B  = 2'd1,
    LOCK_A = 2'd2,
    LOCK_B = 2'd3
  } arb_state_e;

  localparam int DATA_W_DEF    = 16;
  localparam int ADDR_W_DEF    = 3;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/wb_mux_reg.sv
// Selects the winning requester's address/data and registers one write-back beat.
module wb_mux_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              xfer_i,
  input  logic              win_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] data_b_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              sel_o
);

  logic [ADDR_W+DATA_W-1:0] field_d;
  logic [ADDR_W+DATA_W-1:0] field_q;
  logic                     wr_en_q;
  logic                     sel_q;

  always_comb begin
    field_d = win_a_i ? {addr_a_i, data_a_i} : {addr_b_i, data_b_i};
  end

  // Address/data/sel hold their last value on idle cycles; only the strobe drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q <= 1'b0;
      field_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      wr_en_q <= xfer_i;
      if (xfer_i) begin
        field_q <= field_d;
        sel_q   <= win_a_i;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = field_q[ADDR_W+DATA_W-1:DATA_W];
  assign wr_data_o = field_q[DATA_W-1:0];
  assign sel_o     = sel_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port (ALU result A, load data B).
// Define ARB_LOCK_EN to add lock_a/lock_b and bounded locked bursts of up to MAX_BURST grants.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
`ifdef ARB_LOCK_EN
  ,
  parameter int MAX_BURST = MAX_BURST_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_b,
`ifdef ARB_LOCK_EN
  input  logic              lock_a,
  input  logic              lock_b,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              sel
);

  arb_state_e state_q, state_d;
  logic       pri_a;
  logic       gnt_a_c, gnt_b_c;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_a, hold_b;

  // A lock state whose burst has ended arbitrates exactly like PRI of the other side,
  // so a waiting requester is granted in the very first cycle after the burst.
  always_comb begin
    pri_a   = 1'b1;
    hold_a  = 1'b0;
    hold_b  = 1'b0;
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      PRI_A:  pri_a = 1'b1;
      PRI_B:  pri_a = 1'b0;
      LOCK_A: begin
        hold_a = req_a && lock_a && (cnt_q < CNT_W'(MAX_BURST));
        pri_a  = 1'b0;
      end
      LOCK_B: begin
        hold_b = req_b && lock_b && (cnt_q < CNT_W'(MAX_BURST));
        pri_a  = 1'b1;
      end
      default: pri_a = 1'b1;
    endcase

    if (hold_a)      gnt_a_c = 1'b1;
    else if (hold_b) gnt_b_c = 1'b1;
    else if (pri_a) begin
      gnt_a_c = req_a;
      gnt_b_c = !req_a && req_b;
    end else begin
      gnt_b_c = req_b;
      gnt_a_c = !req_b && req_a;
    end

    if (hold_a || hold_b) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (gnt_a_c) begin
      state_d = lock_a ? LOCK_A : PRI_B;
      cnt_d   = lock_a ? CNT_W'(1) : '0;
    end else if (gnt_b_c) begin
      state_d = lock_b ? LOCK_B : PRI_A;
      cnt_d   = lock_b ? CNT_W'(1) : '0;
    end else begin
      state_d = pri_a ? PRI_A : PRI_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRI_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    pri_a   = (state_q != PRI_B);
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    state_d = state_q;
    if (pri_a) begin
      gnt_a_c = req_a;
      gnt_b_c = !req_a && req_b;
    end else begin
      gnt_b_c = req_b;
      gnt_a_c = !req_b && req_a;
    end
    if (gnt_a_c)      state_d = PRI_B;
    else if (gnt_b_c) state_d = PRI_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRI_A;
    else        state_q <= state_d;
  end
`endif

  assign gnt_a = rst_n && gnt_a_c;
  assign gnt_b = rst_n && gnt_b_c;

  wb_mux_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mux_reg (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .xfer_i   (gnt_a || gnt_b),
    .win_a_i  (gnt_a),
    .addr_a_i (addr_a),
    .data_a_i (data_a),
    .addr_b_i (addr_b),
    .data_b_i (data_b),
    .wr_en_o  (wr_en),
    .wr_addr_o(wr_addr),
    .wr_data_o(wr_data),
    .sel_o    (sel)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Table-driven bench for wb_port_arbiter; write-back beats are checked through a scoreboard queue.
// Lock-burst sequences are exercised when ARB_LOCK_EN is defined.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b, la, lb;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b, wr_en, sel;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;

  wb_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (req_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .gnt_a  (gnt_a),
    .req_b  (req_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .gnt_b  (gnt_b),
`ifdef ARB_LOCK_EN
    .lock_a (la),
    .lock_b (lb),
`endif
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .sel    (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ra, rb, la, lb;
    logic [2:0]  aa, ab;
    logic [15:0] da, db;
    logic        ga, gb;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    logic        s;
  } beat_t;

  vec_t  tbl[$];
  beat_t sbq[$];
  bit    pending;
  logic [2:0]  last_a;
  logic [15:0] last_d;
  logic        last_s;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ra, input logic rb, input logic l_a, input logic l_b,
                     input logic ga, input logic gb);
    vec_t v;
    int   n;
    n    = tbl.size();
    v.ra = ra; v.rb = rb; v.la = l_a; v.lb = l_b;
    v.aa = 3'(n);
    v.ab = 3'(7 - (n % 8));
    v.da = 16'hA000 | 16'(n);
    v.db = 16'hB000 | 16'(n);
    v.ga = ga; v.gb = gb;
    tbl.push_back(v);
  endtask

  // Entered at posedge+1; returns at the following posedge+1.
  task automatic step(input vec_t v, input string tag);
    beat_t b;
    req_a = v.ra; req_b = v.rb; la = v.la; lb = v.lb;
    addr_a = v.aa; data_a = v.da; addr_b = v.ab; data_b = v.db;
    @(negedge clk);
    if (pending) begin
      if (sbq.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        b = sbq.pop_front();
        chk({tag, "_wr_en"},   32'(wr_en),   32'd1);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(b.a));
        chk({tag, "_wr_data"}, 32'(wr_data), 32'(b.d));
        chk({tag, "_sel"},     32'(sel),     32'(b.s));
        last_a = b.a; last_d = b.d; last_s = b.s;
      end
    end else begin
      chk({tag, "_wr_en_idle"},  32'(wr_en),   32'd0);
      chk({tag, "_hold_addr"},   32'(wr_addr), 32'(last_a));
      chk({tag, "_hold_data"},   32'(wr_data), 32'(last_d));
      chk({tag, "_hold_sel"},    32'(sel),     32'(last_s));
    end
    pending = 1'b0;
    chk({tag, "_gnt_a"}, 32'(gnt_a), 32'(v.ga));
    chk({tag, "_gnt_b"}, 32'(gnt_b), 32'(v.gb));
    if (v.ga) begin
      b.a = v.aa; b.d = v.da; b.s = 1'b1;
      sbq.push_back(b); pending = 1'b1;
    end else if (v.gb) begin
      b.a = v.ab; b.d = v.db; b.s = 1'b0;
      sbq.push_back(b); pending = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s%0d", tag, i));
    tbl.delete();
  endtask

  initial begin
    pending = 1'b0;
    last_a = '0; last_d = '0; last_s = 1'b0;
    rst_n = 1'b0;
    req_a = 1'b1; addr_a = 3'd3; data_a = 16'h1234;
    req_b = 1'b0; addr_b = '0; data_b = '0; la = 1'b0; lb = 1'b0;
    #12;
    chk("rst_gnt_a",   32'(gnt_a),   32'd0);
    chk("rst_gnt_b",   32'(gnt_b),   32'd0);
    chk("rst_wr_en",   32'(wr_en),   32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_sel",     32'(sel),     32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin: first grant after reset, alternation, no rotation on idle/B-only cycles.
    add(1, 0, 0, 0, 1, 0);
    tbl[0].aa = 3'd3; tbl[0].da = 16'h1234;
    add(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add(1, 1, 0, 0, 1, 0);
      add(1, 1, 0, 0, 0, 1);
    end
    add(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1);
    run_table("rr");

    // Asynchronous reset while a beat sits in the output register.
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wr_en",   32'(wr_en),   32'd0);
    chk("async_gnt_a",   32'(gnt_a),   32'd0);
    chk("async_gnt_b",   32'(gnt_b),   32'd0);
    chk("async_wr_data", 32'(wr_data), 32'd0);
    chk("async_wr_addr", 32'(wr_addr), 32'd0);
    sbq.delete();
    pending = 1'b0;
    last_a = '0; last_d = '0; last_s = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    add(1, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    run_table("post");

`ifdef ARB_LOCK_EN
    // Locked A burst capped at four beats, then B, then plain alternation.
    for (int i = 0; i < 4; i++) add(1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1, 0);
    // Locked B burst cut short by lock_b dropping; waiting A wins next.
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 0, 1, 0, 1);
    add(1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    run_table("lock");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Two-requester arbiter and register stage for the processor's single register-file write port. It grants the port to the ALU-result requester (A) or the load-data requester (B) each cycle using round-robin priority. It also drives the 2:1 select for the 16-bit write-data path and registers the winning address/data into one write-back beat. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- DATA_W, 16, write-data width
- ADDR_W, 3, register address width
- MAX_BURST, 4, maximum consecutive locked grants (used only with ARB_LOCK_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_a  in  1  requester A wants the port
- addr_a  in  ADDR_W  A destination register
- data_a  in  DATA_W  A write data
- gnt_a  out  1  A granted this cycle (combinational)
- req_b, addr_b, data_b, gnt_b: same as A, for requester B
- lock_a, lock_b  in  1  hold-grant request (present only with ARB_LOCK_EN)
- wr_en  out  1  register-file write strobe (registered)
- wr_addr  out  ADDR_W  registered destination
- wr_data  out  DATA_W  registered write data
- sel  out  1  registered select: 1 = beat came from A, 0 = from B

## Operation
- A transfer occurs for X at a rising edge where req_X && gnt_X.
- Requesters hold req/addr/data stable until granted. Dropping req before grant is legal, and that request is lost.
- At most one of gnt_a/gnt_b is high. A grant is never issued without the matching req.
- FSM states: PRI_A, PRI_B, LOCK_A, LOCK_B. LOCK_* exist only with ARB_LOCK_EN.
- PRI_A:
  - req_a high: grant A, next state PRI_B.
  - Else req_b high: grant B, stay in PRI_A.
  - Else no grant, stay.
- PRI_B mirrors PRI_A with A and B swapped.
- A single requester is granted every cycle, back-to-back, with no bubbles.
- When both requesters are continuously active, grants strictly alternate.
- The state only advances on an actual transfer. Priority is not rotated by idle cycles.
- Output stage:
  - On a transfer, the next edge loads wr_en=1, wr_addr/wr_data from the winner, and sel = winner is A.
  - With no transfer, wr_en=0. wr_addr, wr_data and sel hold their previous values.

## Timing
- Grant latency: 0 cycles. gnt is combinational from req and state.
- Write latency: 1 cycle. wr_en is high in the cycle after the transfer edge.
- Throughput: 1 write per cycle.
- Reset, asynchronous:
  - state=PRI_A, wr_en=0, wr_addr=0, wr_data=0, sel=0, burst counter=0.
  - gnt_a and gnt_b are forced 0 while rst_n is low.
- Reset mid-burst aborts the burst. Any beat in the output register is discarded (wr_en=0).
- First edge after rst_n deasserts: normal arbitration from PRI_A.

## Configuration
- ARB_LOCK_EN defined:
  - lock_a/lock_b ports exist.
  - A transfer by X with lock_X=1 enters LOCK_X. The burst counter is loaded with 1.
  - In LOCK_X, X is granted exclusively while req_X && lock_X && count < MAX_BURST. The counter increments on each transfer.
  - The burst ends when lock_X drops, req_X drops, or count == MAX_BURST. The state then goes to PRI of the other requester.
  - A pending request from the other side is granted on the first cycle after the burst ends.
- ARB_LOCK_EN undefined:
  - No lock ports, no LOCK states, no counter.
  - Pure round-robin as described under Operation.

## Structure
- Package wb_arb_pkg holds:
  - FSM state encoding constants (2-bit).
  - DATA_W/ADDR_W default constants.
  - MAX_BURST default.
- Sub-module wb_mux_reg: DATA_W+ADDR_W-wide 2:1 select of A/B fields, plus the output register for wr_en/wr_addr/wr_data/sel. It is driven by the FSM's winner and transfer signals.
- The FSM and the optional burst counter stay in wb_port_arbiter.

## Test plan
- Reset release with req_a=1, addr_a=3, data_a=16'h1234:
  - gnt_a=1 in the first cycle.
  - Next cycle: wr_en=1, wr_addr=3, wr_data=16'h1234, sel=1.
- Both req held high for 6 cycles: grant order A,B,A,B,A,B, and wr_en stays high for 6 consecutive cycles.
- Only req_b for 4 cycles, then both high: B granted 4 times, then A first, because priority did not rotate while A was idle.
- Assert rst_n=0 asynchronously mid-stream with wr_en=1:
  - wr_en, gnt_a and gnt_b go to 0 immediately.
  - wr_data becomes 0 without waiting for a clock edge.
- ARB_LOCK_EN, MAX_BURST=4: lock_a=1, both requesting continuously. Grants are A,A,A,A,B, then alternation continues.
- ARB_LOCK_EN: lock_b drops after 2 locked beats while A is waiting. A is granted in the next cycle.
